// File: rtl/ntt_pkg.sv
// Shared constants and state type for the inverse-NTT
// job arbiter and its neighbours.
package ntt_pkg;
  localparam int NTT_Q = 17;
  localparam int NTT_N = 8;
  localparam int NTT_LOGN = 3;
  localparam int NTT_LOGQ = 5;
  localparam int NTT_N_INV = 15;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    LOAD,
    DRAIN
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after
// rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GW-1:0]      rr_ptr,
  output logic [GW-1:0]      winner,
  output logic               any
);
  logic [GW-1:0] idx;

  // Scan farthest-first so the nearest hit wins.
  always_comb begin
    winner = rr_ptr;
    idx = '0;
    any = |req_valid;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/intt_job_arbiter.sv
// Grants one shared streaming INTT core to a requester for a
// whole job: N beats in, then N beats out.
module intt_job_arbiter
  import ntt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int N = NTT_N,
  parameter int logN = NTT_LOGN,
  parameter int logq = NTT_LOGQ,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*logq-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [logq-1:0]         resp_data,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic                    core_in_valid,
  output logic [logq-1:0]         core_in_data,
  input  logic                    core_in_ready,
  input  logic                    core_out_valid,
  input  logic [logq-1:0]         core_out_data,
  output logic                    core_out_ready,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic                    job_done
);
  arb_state_t    state;
  logic [logN:0] cnt;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] winner;
  logic          any;
  logic          in_fire;
  logic          out_fire;
  logic          last;
  logic [GW-1:0] next_ptr;
  logic [logq-1:0] lane [NUM_REQ];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any       (any)
  );

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_lane
    assign lane[r] = req_data[r*logq +: logq];
  end

  assign in_fire = (state == LOAD) && req_valid[grant_id]
                && core_in_ready;
  assign out_fire = (state == DRAIN) && core_out_valid
                 && resp_ready[grant_id];
  assign last = (cnt == (logN+1)'(N - 1));
  assign next_ptr = (grant_id == GW'(NUM_REQ - 1))
                  ? '0 : grant_id + 1'b1;
  assign busy = (state != IDLE);
  assign resp_data = core_out_data;

  always_comb begin
    req_ready = '0;
    resp_valid = '0;
    core_in_valid = 1'b0;
    core_in_data = '0;
    core_out_ready = 1'b0;
    if (state == LOAD) begin
      req_ready[grant_id] = core_in_ready;
      core_in_valid = req_valid[grant_id];
      core_in_data = lane[grant_id];
    end
    if (state == DRAIN) begin
      resp_valid[grant_id] = core_out_valid;
      core_out_ready = resp_ready[grant_id];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      rr_ptr <= '0;
      grant_id <= '0;
      job_done <= 1'b0;
    end else begin
      job_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_valid) state <= ARB;
        end
        ARB: begin
          // An empty ARB cycle keeps the previous owner.
          if (any) begin
            grant_id <= winner;
            cnt <= '0;
            state <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (in_fire) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
              state <= IDLE;
              job_done <= 1'b1;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
